// File: rtl/div_iter_unit_pkg.sv
// Shared encodings for the iterative divider: operation codes, FSM states
// and the radix legality check.
package div_iter_unit_pkg;

    typedef enum logic [1:0] {
        DIV_OP  = 2'b00,
        DIVU_OP = 2'b01,
        REM_OP  = 2'b10,
        REMU_OP = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ITER = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } div_state_e;

    localparam int unsigned DIV_RADIX_MAX = 32'd2;

    function automatic bit div_radix_legal(input int unsigned radix_bits);
        return (radix_bits >= 32'd1) && (radix_bits <= DIV_RADIX_MAX);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the
// divisor on XLEN+1 bits and keep the difference when it is non-negative.
module div_restore_step
    import div_iter_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] prev_rem,
    input  logic            next_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] next_rem,
    output logic            q_bit
);

    logic [XLEN:0] shifted_s;
    logic [XLEN:0] trial_s;

    // prev_rem < divisor, so the XLEN+1-bit difference never wraps and its MSB is the sign
    assign shifted_s = {prev_rem, next_bit};
    assign trial_s   = shifted_s - {1'b0, divisor};
    assign q_bit     = ~trial_s[XLEN];
    assign next_rem  = q_bit ? trial_s[XLEN-1:0] : shifted_s[XLEN-1:0];

endmodule

// File: rtl/div_iter_unit.sv
// Iterative DIV/DIVU/REM/REMU unit with start/busy/valid handshake.
// Optional macro DIV_EARLY_OUT_EN: leading-zero early-out shortens latency for small dividends.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int RADIX_BITS = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    input  logic            busywait_i,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int ITERS = XLEN / RADIX_BITS;
    localparam int CNT_W = $clog2(ITERS + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    if (!div_radix_legal(RADIX_BITS) || ((XLEN % RADIX_BITS) != 0)) begin : g_bad_cfg
        $error("div_iter_unit: RADIX_BITS must be 1 or 2 and divide XLEN");
    end

    div_state_e      state_r, next_state_s;
    div_op_e         op_r;
    logic [XLEN-1:0] dvd_r, dvs_r, rem_r, result_r;
    logic [CNT_W-1:0] cnt_r, load_cnt_s;
    logic            q_neg_r, r_neg_r, valid_r;
    logic            busy_s, valid_d_s;

    logic            signed_op_s, is_rem_s, a_neg_s, b_neg_s;
    logic            zero_div_s, ovf_s, fast_s;
    logic [XLEN-1:0] a_abs_s, b_abs_s, fast_result_s, load_dvd_s;
    logic [XLEN-1:0] q_fix_s, r_fix_s, fix_result_s;
    logic [XLEN-1:0] chain_rem_s [RADIX_BITS+1];
    logic [RADIX_BITS-1:0] q_bits_s;

    assign signed_op_s = (op_i == DIV_OP) || (op_i == REM_OP);
    assign is_rem_s    = (op_i == REM_OP) || (op_i == REMU_OP);
    assign a_neg_s     = signed_op_s & dividend_i[XLEN-1];
    assign b_neg_s     = signed_op_s & divisor_i[XLEN-1];
    assign a_abs_s     = a_neg_s ? (ZERO - dividend_i) : dividend_i;
    assign b_abs_s     = b_neg_s ? (ZERO - divisor_i) : divisor_i;

    // Zero divisor and signed overflow resolve without iterating
    assign zero_div_s    = (divisor_i == ZERO);
    assign ovf_s         = signed_op_s && (dividend_i == MIN_NEG) && (divisor_i == ONES);
    assign fast_s        = zero_div_s | ovf_s;
    assign fast_result_s = zero_div_s ? (is_rem_s ? dividend_i : ONES)
                                      : (is_rem_s ? ZERO : dividend_i);

`ifdef DIV_EARLY_OUT_EN
    // Leading-zero count trims the iteration count and pre-aligns the dividend
    always_comb begin
        int lz_v;
        int n_v;
        lz_v = XLEN;
        for (int i = 0; i < XLEN; i++) begin
            if (a_abs_s[i]) lz_v = XLEN - 1 - i;
            else            lz_v = lz_v;
        end
        n_v = (XLEN - lz_v + RADIX_BITS - 1) / RADIX_BITS;
        if (n_v < 1) n_v = 1;
        else         n_v = n_v;
        load_cnt_s = CNT_W'(n_v);
        load_dvd_s = a_abs_s << (XLEN - n_v * RADIX_BITS);
    end
`else
    assign load_cnt_s = CNT_FULL;
    assign load_dvd_s = a_abs_s;
`endif

    // Restoring steps chained so one cycle retires RADIX_BITS quotient bits
    assign chain_rem_s[0] = rem_r;
    for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
        div_restore_step #(.XLEN(XLEN)) u_step (
            .prev_rem (chain_rem_s[g]),
            .next_bit (dvd_r[XLEN-1-g]),
            .divisor  (dvs_r),
            .next_rem (chain_rem_s[g+1]),
            .q_bit    (q_bits_s[RADIX_BITS-1-g])
        );
    end

    // Sign correction and quotient/remainder select for the FIX cycle
    assign q_fix_s = q_neg_r ? (ZERO - dvd_r) : dvd_r;
    assign r_fix_s = r_neg_r ? (ZERO - rem_r) : rem_r;
    always_comb begin
        fix_result_s = q_fix_s;
        case (op_r)
            DIV_OP, DIVU_OP: fix_result_s = q_fix_s;
            REM_OP, REMU_OP: fix_result_s = r_fix_s;
            default:         fix_result_s = q_fix_s;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // FSM next-state logic; flush overrides everything
    always_comb begin
        next_state_s = state_r;
        if (flush_i) begin
            next_state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_i) next_state_s = fast_s ? ST_DONE : ST_ITER;
                    else         next_state_s = ST_IDLE;
                end
                ST_ITER: next_state_s = (cnt_r == CNT_ONE) ? ST_FIX : ST_ITER;
                ST_FIX:  next_state_s = ST_DONE;
                ST_DONE: next_state_s = busywait_i ? ST_DONE : ST_IDLE;
                default: next_state_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: busy is combinational from start so the stall lands in the request cycle
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            ST_IDLE:         busy_s = start_i & ~flush_i;
            ST_ITER, ST_FIX: busy_s = 1'b1;
            ST_DONE:         busy_s = 1'b0;
            default:         busy_s = 1'b0;
        endcase
        valid_d_s = (next_state_s == ST_DONE);
    end

    // Operand latch, iteration datapath and result register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_r     <= DIV_OP;
            dvd_r    <= ZERO;
            dvs_r    <= ZERO;
            rem_r    <= ZERO;
            cnt_r    <= {CNT_W{1'b0}};
            q_neg_r  <= 1'b0;
            r_neg_r  <= 1'b0;
            valid_r  <= 1'b0;
            result_r <= ZERO;
        end else begin
            valid_r <= valid_d_s;
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_r    <= div_op_e'(op_i);
                        dvd_r   <= load_dvd_s;
                        dvs_r   <= b_abs_s;
                        rem_r   <= ZERO;
                        cnt_r   <= load_cnt_s;
                        q_neg_r <= a_neg_s ^ b_neg_s;
                        r_neg_r <= a_neg_s;
                        if (fast_s) result_r <= fast_result_s;
                    end
                end
                ST_ITER: begin
                    dvd_r <= {dvd_r[XLEN-1-RADIX_BITS:0], q_bits_s};
                    rem_r <= chain_rem_s[RADIX_BITS];
                    cnt_r <= cnt_r - CNT_ONE;
                end
                ST_FIX: begin
                    if (!flush_i) result_r <= fix_result_s;
                end
                default: ;
            endcase
        end
    end

    assign busy_o   = busy_s;
    assign valid_o  = valid_r;
    assign result_o = result_r;

endmodule
